// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: stage hold bit
// positions, canned hold vectors and the sequencer state encoding.
package pipeline_stall_ctrl_pkg;

    typedef logic [5:0] stall_vec_t;

    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;
    localparam int STALL_EX = 3;

    localparam stall_vec_t STALL_NONE = 6'b000000;
    // Holding PC..IF_ID while releasing ID_EX inserts exactly one bubble into ID_EX.
    localparam stall_vec_t STALL_LU   = stall_vec_t'((1 << STALL_PC) | (1 << STALL_IF) | (1 << STALL_ID));
    localparam stall_vec_t STALL_MC   = stall_vec_t'(STALL_LU | (1 << STALL_EX));

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MC_WAIT = 2'd1;

endpackage

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the
// source operands of the instruction in ID.
module load_use_detect (
    input  logic [4:0] rs_addr,
    input  logic       rs_read,
    input  logic [4:0] rt_addr,
    input  logic       rt_read,
    input  logic       is_load,
    input  logic [4:0] write_addr,
    input  logic       write_enable,
    output logic       lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = rs_read && (rs_addr == write_addr);
    assign rt_hit = rt_read && (rt_addr == write_addr);

    // $0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign lu = is_load && write_enable && (write_addr != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, multi-cycle
// EX op handshake with timeout, MEM exception flushes and a stall-cycle counter.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs_addr_i,
    input  logic             id_rs_read_i,
    input  logic [4:0]       id_rt_addr_i,
    input  logic             id_rt_read_i,
    input  logic             ex_is_load_i,
    input  logic [4:0]       ex_writeAddr_i,
    input  logic             ex_writeEnable_i,
    input  logic             ex_multicycle_i,
    input  logic             ex_mc_done_i,
    input  logic             exception_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic             ex_mc_start_o,
    output logic             mc_abort_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int TMR_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [TMR_W-1:0] timer;
    logic             lu;
    logic             timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    load_use_detect u_load_use_detect (
        .rs_addr      (id_rs_addr_i),
        .rs_read      (id_rs_read_i),
        .rt_addr      (id_rt_addr_i),
        .rt_read      (id_rt_read_i),
        .is_load      (ex_is_load_i),
        .write_addr   (ex_writeAddr_i),
        .write_enable (ex_writeEnable_i),
        .lu           (lu)
    );

    // Controls are combinational from state and inputs; everything is quiet during rst.
    always_comb begin
        stall_o       = STALL_NONE;
        flush_o       = 1'b0;
        ex_mc_start_o = 1'b0;
        mc_abort_o    = 1'b0;
        timeout_hit   = 1'b0;
        state_nxt     = state;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (exception_i) begin
                        flush_o = 1'b1;
                    end else if (ex_multicycle_i) begin
                        ex_mc_start_o = 1'b1;
                        stall_o       = STALL_MC;
                        state_nxt     = ST_MC_WAIT;
                    end else if (lu) begin
                        stall_o = STALL_LU;
                    end
                end
                ST_MC_WAIT: begin
                    if (exception_i) begin
                        flush_o    = 1'b1;
                        mc_abort_o = 1'b1;
                        state_nxt  = ST_RUN;
                    end else if (ex_mc_done_i) begin
                        state_nxt = ST_RUN;
                    end else if (timer == TMR_W'(MC_TIMEOUT - 1)) begin
                        timeout_hit = 1'b1;
                        state_nxt   = ST_RUN;
                    end else begin
                        stall_o = STALL_MC;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            timer        <= '0;
            mc_timeout_o <= 1'b0;
            stall_cnt_o  <= '0;
        end else begin
            state <= state_nxt;
            // Timer idles at zero in RUN so it is already cleared when a wait begins.
            if (state == ST_MC_WAIT) begin
                timer <= timer + TMR_W'(1);
            end else begin
                timer <= '0;
            end
            if (timeout_hit) begin
                mc_timeout_o <= 1'b1;
            end
            if (stall_o != STALL_NONE) begin
                stall_cnt_o <= sat_inc(stall_cnt_o);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: table vectors, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int MC_TIMEOUT = 8;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs_addr, rt_addr, wa;
    logic             rs_rd, rt_rd, ld, we, mc, done, exc;
    logic [5:0]       stall;
    logic             flush, start, abort, tout;
    logic [CNT_W-1:0] cnt;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs_addr_i     (rs_addr),
        .id_rs_read_i     (rs_rd),
        .id_rt_addr_i     (rt_addr),
        .id_rt_read_i     (rt_rd),
        .ex_is_load_i     (ld),
        .ex_writeAddr_i   (wa),
        .ex_writeEnable_i (we),
        .ex_multicycle_i  (mc),
        .ex_mc_done_i     (done),
        .exception_i      (exc),
        .stall_o          (stall),
        .flush_o          (flush),
        .ex_mc_start_o    (start),
        .mc_abort_o       (abort),
        .mc_timeout_o     (tout),
        .stall_cnt_o      (cnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: waiting flag, cycles already spent waiting, sticky flag, counter.
    bit       m_wait, n_wait;
    int       m_waited, n_waited;
    bit       m_tout, n_tout;
    int       m_cnt, n_cnt;
    logic [5:0] e_stall;
    bit       e_flush, e_start, e_abort;

    logic [5:0] o_stall;
    logic       o_flush, o_start, o_abort;
    int         start_pulses;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_eval();
        bit hazard;
        hazard = ld && we && (wa != 0) && ((rs_rd && rs_addr == wa) || (rt_rd && rt_addr == wa));
        e_stall = 6'd0; e_flush = 0; e_start = 0; e_abort = 0;
        n_wait = m_wait; n_waited = m_waited; n_tout = m_tout; n_cnt = m_cnt;
        if (rst) begin
            n_wait = 0; n_waited = 0; n_tout = 0; n_cnt = 0;
        end else begin
            if (!m_wait) begin
                if (exc) e_flush = 1;
                else if (mc) begin
                    e_start = 1; e_stall = 6'b001111; n_wait = 1; n_waited = 0;
                end else if (hazard) e_stall = 6'b000111;
            end else begin
                if (exc) begin
                    e_flush = 1; e_abort = 1; n_wait = 0;
                end else if (done) n_wait = 0;
                else if (m_waited == MC_TIMEOUT - 1) begin
                    n_wait = 0; n_tout = 1;
                end else begin
                    e_stall = 6'b001111; n_waited = m_waited + 1;
                end
            end
            if (e_stall != 0 && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
        end
    endtask

    // Inputs are set by the caller just after a posedge; outputs are sampled at negedge.
    task automatic tick();
        model_eval();
        @(negedge clk);
        o_stall = stall; o_flush = flush; o_start = start; o_abort = abort;
        if (start === 1'b1) start_pulses++;
        chk("stall", 32'(stall), 32'(e_stall));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("start", 32'(start), 32'(e_start));
        chk("abort", 32'(abort), 32'(e_abort));
        @(posedge clk);
        m_wait = n_wait; m_waited = n_waited; m_tout = n_tout; m_cnt = n_cnt;
        #1;
        chk("stall_cnt", 32'(cnt), 32'(m_cnt));
        chk("mc_timeout", 32'(tout), 32'(m_tout));
    endtask

    task automatic clear_in();
        rs_addr = 0; rt_addr = 0; wa = 0;
        rs_rd = 0; rt_rd = 0; ld = 0; we = 0; mc = 0; done = 0; exc = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    typedef struct {
        logic [4:0] rs; logic rs_rd; logic [4:0] rt; logic rt_rd;
        logic ld; logic [4:0] wa; logic we; logic exc;
        logic [5:0] e_stall; logic e_flush;
    } vec_t;
    vec_t tbl[8];

    initial begin
        m_wait = 0; m_waited = 0; m_tout = 0; m_cnt = 0; start_pulses = 0;
        tbl[0] = '{5'd3,  1, 5'd5, 1, 1, 5'd3,  1, 0, 6'b000111, 0};
        tbl[1] = '{5'd0,  1, 5'd5, 0, 1, 5'd0,  1, 0, 6'b000000, 0};
        tbl[2] = '{5'd1,  1, 5'd9, 1, 1, 5'd9,  1, 0, 6'b000111, 0};
        tbl[3] = '{5'd1,  1, 5'd9, 0, 1, 5'd9,  1, 0, 6'b000000, 0};
        tbl[4] = '{5'd3,  1, 5'd3, 1, 0, 5'd3,  1, 0, 6'b000000, 0};
        tbl[5] = '{5'd3,  1, 5'd3, 1, 1, 5'd3,  0, 0, 6'b000000, 0};
        tbl[6] = '{5'd3,  1, 5'd3, 1, 1, 5'd3,  1, 1, 6'b000000, 1};
        tbl[7] = '{5'd31, 1, 5'd2, 0, 1, 5'd31, 1, 0, 6'b000111, 0};

        do_reset();
        chk("reset_cnt", 32'(cnt), 32'd0);
        chk("reset_tout", 32'(tout), 32'd0);

        // Single-cycle load-use / exception vectors in RUN.
        for (int i = 0; i < 8; i++) begin
            clear_in();
            rs_addr = tbl[i].rs; rs_rd = tbl[i].rs_rd; rt_addr = tbl[i].rt; rt_rd = tbl[i].rt_rd;
            ld = tbl[i].ld; wa = tbl[i].wa; we = tbl[i].we; exc = tbl[i].exc;
            tick();
            chk($sformatf("vec%0d_stall", i), 32'(o_stall), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d_flush", i), 32'(o_flush), 32'(tbl[i].e_flush));
            if (i == 0) chk("lu_cnt", 32'(cnt), 32'd1);
        end

        // DIV with done five cycles after start.
        do_reset();
        start_pulses = 0;
        mc = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("div_stall%0d", i), 32'(o_stall), 32'b001111);
        end
        done = 1;
        tick();
        chk("div_done_stall", 32'(o_stall), 32'd0);
        clear_in();
        tick();
        chk("div_run_stall", 32'(o_stall), 32'd0);
        chk("div_cnt", 32'(cnt), 32'd5);
        chk("div_starts", 32'(start_pulses), 32'd1);

        // Exception in the third MC_WAIT cycle aborts the op.
        do_reset();
        mc = 1;
        tick(); tick(); tick();
        exc = 1;
        tick();
        chk("exc_flush", 32'(o_flush), 32'd1);
        chk("exc_abort", 32'(o_abort), 32'd1);
        chk("exc_stall", 32'(o_stall), 32'd0);
        clear_in();
        tick();
        chk("exc_run", 32'({o_stall, o_abort, o_start}), 32'd0);

        // No done: released at timer == MC_TIMEOUT-1, sticky error flag.
        do_reset();
        mc = 1;
        tick();
        mc = 0;
        for (int i = 0; i < MC_TIMEOUT - 1; i++) tick();
        chk("tmo_pre_flag", 32'(tout), 32'd0);
        tick();
        chk("tmo_release", 32'(o_stall), 32'd0);
        chk("tmo_flag", 32'(tout), 32'd1);
        tick(); tick();
        chk("tmo_sticky", 32'(tout), 32'd1);
        do_reset();
        chk("tmo_cleared", 32'(tout), 32'd0);

        // Load-use and multi-cycle together: multi-cycle wins; then rst mid-wait.
        clear_in();
        rs_addr = 5'd7; rs_rd = 1; ld = 1; wa = 5'd7; we = 1; mc = 1;
        tick();
        chk("mcwin_start", 32'(o_start), 32'd1);
        chk("mcwin_stall", 32'(o_stall), 32'b001111);
        tick();
        rst = 1; exc = 1; done = 1;
        tick();
        chk("rst_outs", 32'({o_stall, o_flush, o_start, o_abort}), 32'd0);
        rst = 0;
        clear_in();
        tick();
        chk("rst_run", 32'(o_stall), 32'd0);

        // Counter saturation.
        do_reset();
        rs_addr = 5'd4; rs_rd = 1; ld = 1; wa = 5'd4; we = 1;
        for (int i = 0; i < CNT_MAX + 4; i++) tick();
        chk("cnt_sat", 32'(cnt), 32'(CNT_MAX));

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            exc     = ($urandom_range(0, 9) == 0);
            mc      = ($urandom_range(0, 5) == 0);
            done    = ($urandom_range(0, 6) == 0);
            rs_addr = 5'($urandom_range(0, 3));
            rt_addr = 5'($urandom_range(0, 3));
            wa      = 5'($urandom_range(0, 3));
            rs_rd   = 1'($urandom_range(0, 1));
            rt_rd   = 1'($urandom_range(0, 1));
            ld      = 1'($urandom_range(0, 1));
            we      = 1'($urandom_range(0, 1));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
